// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing logic.
// Imported by hazard_ctrl and its helpers.
package pipe_ctrl_pkg;

  typedef logic [0:0] fsm_t;

  localparam fsm_t RUN   = 1'b0;
  localparam fsm_t DWAIT = 1'b1;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [4:0]  X0  = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs and pipeline-register controls of hazard_ctrl.
// master drives the pipeline status, slave is the controller.
interface hazard_ctrl_if;

  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       use_rs1_id;
  logic       use_rs2_id;
  logic [4:0] rd_ex;
  logic       memread_ex;
  logic       mispredict_ex;
  logic       imem_ready;
  logic       dmem_req_mem;
  logic       dmem_ready;

  logic       pc_enable;
  logic       pc_redirect;
  logic       if_id_enable;
  logic       if_id_clear;
  logic       id_ex_enable;
  logic       id_ex_clear;
  logic       back_enable;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id,
    output rd_ex, memread_ex, mispredict_ex,
    output imem_ready, dmem_req_mem, dmem_ready,
    input  pc_enable, pc_redirect,
    input  if_id_enable, if_id_clear,
    input  id_ex_enable, id_ex_clear, back_enable
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id,
    input  rd_ex, memread_ex, mispredict_ex,
    input  imem_ready, dmem_req_mem, dmem_ready,
    output pc_enable, pc_redirect,
    output if_id_enable, if_id_clear,
    output id_ex_enable, id_ex_clear, back_enable
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones.
// Async active-low reset to zero.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, dmem wait FSM,
// stale-fetch drop tracking, timeout watchdog and perf counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DMEM_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  fsm_t            state_q;
  fsm_t            state_d;
  logic [TO_W-1:0] wcnt_q;
  logic [TO_W-1:0] wcnt_d;
  logic [TO_W-1:0] wcnt_inc;
  logic            drop_q;
  logic            drop_d;
  logic            to_d;

  logic dwait;
  logic hit1;
  logic hit2;
  logic lu;
  logic fetch_bad;
  logic sel_dw;
  logic sel_mp;
  logic sel_lu;
  logic sel_fb;

  logic pc_en;
  logic pc_redir;
  logic ifid_en;
  logic ifid_clr;
  logic idex_en;
  logic idex_clr;
  logic back_en;

  assign dwait = hz.dmem_req_mem & ~hz.dmem_ready;
  assign hit1  = hz.use_rs1_id & (hz.rs1_id == hz.rd_ex);
  assign hit2  = hz.use_rs2_id & (hz.rs2_id == hz.rd_ex);
  assign lu    = hz.memread_ex & (hz.rd_ex != X0) & (hit1 | hit2);

  assign fetch_bad = ~hz.imem_ready | drop_q;

  // One-hot selects encode the priority order
  assign sel_dw = dwait;
  assign sel_mp = ~dwait & hz.mispredict_ex;
  assign sel_lu = ~dwait & ~hz.mispredict_ex & lu;
  assign sel_fb = ~dwait & ~hz.mispredict_ex & ~lu & fetch_bad;

  always_comb begin
    pc_en    = 1'b1;
    pc_redir = 1'b0;
    ifid_en  = 1'b1;
    ifid_clr = 1'b0;
    idex_en  = 1'b1;
    idex_clr = 1'b0;
    back_en  = 1'b1;
    unique case (1'b1)
      sel_dw: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        back_en = 1'b0;
      end
      sel_mp: begin
        pc_redir = 1'b1;
        ifid_clr = 1'b1;
        idex_clr = 1'b1;
      end
      sel_lu: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_clr = 1'b1;
      end
      sel_fb: begin
        pc_en    = 1'b0;
        ifid_clr = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.pc_enable    = pc_en;
  assign hz.pc_redirect  = pc_redir;
  assign hz.if_id_enable = ifid_en;
  assign hz.if_id_clear  = ifid_clr;
  assign hz.id_ex_enable = idex_en;
  assign hz.id_ex_clear  = idex_clr;
  assign hz.back_enable  = back_en;

  // A redirect with no fetch data leaves a stale fetch to discard
  always_comb begin
    drop_d = drop_q;
    if (sel_mp) begin
      drop_d = ~hz.imem_ready;
    end else if (sel_fb && drop_q && hz.imem_ready) begin
      drop_d = 1'b0;
    end
  end

  assign state_d  = dwait ? DWAIT : RUN;
  assign wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;

  always_comb begin
    wcnt_d = '0;
    to_d   = dmem_timeout;
    if ((state_q == DWAIT) && dwait) begin
      wcnt_d = wcnt_inc;
      if (wcnt_inc == TO_W'(DMEM_TIMEOUT)) begin
        to_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      wcnt_q       <= '0;
      drop_q       <= 1'b0;
      dmem_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      drop_q       <= drop_d;
      dmem_timeout <= to_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (sel_mp),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed plan cases plus random
// traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int CW  = 4;
  localparam int TMO = 3;
  localparam int MX  = (1 << CW) - 1;

  typedef struct packed {
    logic          pc_en;
    logic          redir;
    logic          ife;
    logic          ifc;
    logic          ide;
    logic          idc;
    logic          be;
    logic          to;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          dmem_timeout;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_events;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .CNT_W        (CW),
    .DMEM_TIMEOUT (TMO),
    .TO_W         (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hz),
    .dmem_timeout (dmem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_chk;
  int   n_fail;

  int m_drop;
  int m_run;
  int m_stall;
  int m_flush;
  int m_to;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask

  // Monitor: compares every sampled cycle against the queued model result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_enable", 32'(hz.pc_enable), 32'(e.pc_en));
        chk("pc_redirect", 32'(hz.pc_redirect), 32'(e.redir));
        chk("if_id_enable", 32'(hz.if_id_enable), 32'(e.ife));
        chk("if_id_clear", 32'(hz.if_id_clear), 32'(e.ifc));
        chk("id_ex_enable", 32'(hz.id_ex_enable), 32'(e.ide));
        chk("id_ex_clear", 32'(hz.id_ex_clear), 32'(e.idc));
        chk("back_enable", 32'(hz.back_enable), 32'(e.be));
        chk("dmem_timeout", 32'(dmem_timeout), 32'(e.to));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.stall));
        chk("flush_events", 32'(flush_events), 32'(e.flush));
      end
    end
  end

  task automatic step(
    input int rs1, input int rs2, input bit u1, input bit u2,
    input int rd, input bit mr, input bit mp, input bit ir,
    input bit dq, input bit dr, input bit rst_n
  );
    exp_t e;
    bit   dw;
    bit   lu;
    @(posedge clk);
    #1;
    hz.rs1_id        = 5'(rs1);
    hz.rs2_id        = 5'(rs2);
    hz.use_rs1_id    = u1;
    hz.use_rs2_id    = u2;
    hz.rd_ex         = 5'(rd);
    hz.memread_ex    = mr;
    hz.mispredict_ex = mp;
    hz.imem_ready    = ir;
    hz.dmem_req_mem  = dq;
    hz.dmem_ready    = dr;
    reset            = rst_n;
    if (!rst_n) begin
      m_drop = 0; m_run = 0; m_stall = 0; m_flush = 0; m_to = 0;
    end
    dw = dq && !dr;
    lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e = '0;
    e.pc_en = 1; e.ife = 1; e.ide = 1; e.be = 1;
    if (dw) begin
      e.pc_en = 0; e.ife = 0; e.ide = 0; e.be = 0;
    end else if (mp) begin
      e.redir = 1; e.ifc = 1; e.idc = 1;
    end else if (lu) begin
      e.pc_en = 0; e.ife = 0; e.idc = 1;
    end else if (!ir || m_drop != 0) begin
      e.pc_en = 0; e.ifc = 1;
    end
    e.to    = (m_to != 0);
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
    q.push_back(e);
    if (rst_n) begin
      if (!e.pc_en && m_stall < MX) m_stall++;
      if (!dw && mp && m_flush < MX) m_flush++;
      if (!dw && mp) m_drop = ir ? 0 : 1;
      else if (!dw && !lu && m_drop != 0 && ir) m_drop = 0;
      m_run = dw ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      if (m_run >= TMO + 1) m_to = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
  endtask

  initial begin
    int w;
    n_chk = 0; n_fail = 0;
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    // load-use, then same pattern targeting x0
    step(5, 0, 1, 0, 5, 1, 0, 1, 0, 0, 1);
    idle(1);
    step(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1);
    idle(1);
    // mispredict with fetch ready
    step(1, 2, 1, 1, 3, 0, 1, 1, 0, 0, 1);
    idle(2);
    // mispredict without fetch, ready three cycles later
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(2);
    // dmem wait overlapping a load-use
    for (int i = 0; i < 4; i++) step(7, 0, 1, 0, 7, 1, 0, 1, 1, 0, 1);
    step(7, 0, 1, 0, 7, 1, 0, 1, 1, 1, 1);
    idle(2);
    // watchdog: long wait, sticky flag
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    idle(3);
    // async reset in the middle of a wait
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom), 1'($urandom),
           $urandom_range(0, 3), 1'($urandom),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) >= 1));
    end
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage RISC-V core.
- Generates the enable/clear controls for the PC register and the IF/ID, ID/EX and EX/MEM+MEM/WB pipeline registers.
- Detects load-use hazards, branch mispredicts (resolved in EX) and instruction/data-memory wait states.
- Tracks a stale in-flight fetch after a redirect, runs a data-memory timeout watchdog, and keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the stall_cycles and flush_events counters.
- DMEM_TIMEOUT, 255, maximum consecutive data-memory wait cycles before dmem_timeout is raised.
- TO_W, 8, width of the wait counter; must satisfy 2^TO_W > DMEM_TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- rs1_id  in  5  ID-stage source register 1
- rs2_id  in  5  ID-stage source register 2
- use_rs1_id  in  1  ID instruction reads rs1
- use_rs2_id  in  1  ID instruction reads rs2
- rd_ex  in  5  EX-stage destination register
- memread_ex  in  1  EX instruction is a load
- mispredict_ex  in  1  EX branch/jump outcome differs from the IF prediction
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req_mem  in  1  MEM stage has an access in progress
- dmem_ready  in  1  data memory completes the access this cycle
- pc_enable  out  1  PC register load enable
- pc_redirect  out  1  PC selects the corrected EX target
- if_id_enable  out  1  IF/ID load enable
- if_id_clear  out  1  IF/ID loads a NOP (addi x0,x0,0)
- id_ex_enable  out  1  ID/EX load enable
- id_ex_clear  out  1  ID/EX loads a bubble
- back_enable  out  1  EX/MEM and MEM/WB load enable
- dmem_timeout  out  1  sticky error flag
- stall_cycles  out  CNT_W  saturating count of cycles with pc_enable=0
- flush_events  out  CNT_W  saturating count of mispredict flushes

Behaviour:
- Reset (async, reset=0):
  - FSM = RUN; wait counter = 0; drop flag = 0.
  - stall_cycles = 0, flush_events = 0, dmem_timeout = 0.
  - Control outputs take their RUN values for the current inputs.
- Control outputs are combinational from the FSM state, the drop flag and the current inputs. They act in the same cycle; zero added latency.
- Conditions:
  - dwait = dmem_req_mem & ~dmem_ready
  - lu = memread_ex & rd_ex≠0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex))
- FSM states: RUN, DWAIT.
  - RUN→DWAIT on dwait.
  - DWAIT→RUN on dmem_ready.
  - DWAIT holds while dwait.
- Priority, highest first: dwait > mispredict_ex > lu > fetch not usable. A fetch is not usable when imem_ready=0 or the drop flag is set.
- dwait (either state):
  - All enables = 0: full freeze. No clears.
  - mispredict_ex and lu are ignored this cycle; the instruction stays in EX and is re-evaluated after the wait.
- mispredict_ex:
  - pc_enable=1, pc_redirect=1.
  - if_id_clear=1, id_ex_clear=1; back_enable=1.
  - flush_events += 1 (saturating).
  - If imem_ready=0 this cycle, set the drop flag so the stale fetch is discarded.
- lu:
  - pc_enable=0, if_id_enable=0, id_ex_clear=1, back_enable=1.
  - Exactly one bubble per load-use pair.
- Fetch not usable:
  - pc_enable=0, if_id_clear=1; ID/EX and back stages advance.
  - If the drop flag is set and imem_ready=1, clear the drop flag at this clock edge. The discarded fetch is not loaded.
- Default: all enables=1, clears=0, pc_redirect=0.
- Whenever a clear and an enable target the same register, the clear is authoritative.
- Wait counter:
  - Increments each DWAIT cycle (saturating) and resets to 0 on leaving DWAIT.
  - When the counter equals DMEM_TIMEOUT, dmem_timeout sets. It stays set until reset.
- Counters saturate at all-ones and never wrap.
- A reset asserted mid-stall abandons DWAIT and the drop flag immediately.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state typedef (RUN, DWAIT);
  - NOP encoding constant 32'h0000_0013;
  - x0 register index constant.
- One natural sub-module: sat_counter (parameter W; inc, count). Instantiated twice for stall_cycles and flush_events.
- The FSM and hazard logic stay in the top level.

Test Plan:
- Load-use: lw x5 in EX (memread_ex=1, rd_ex=5), ID uses rs1=5, use_rs1_id=1 → one cycle of pc_enable=0, if_id_enable=0, id_ex_clear=1; stall_cycles=1. With rd_ex=0 instead → no stall.
- Mispredict with imem_ready=1 → pc_redirect=1, if_id_clear=1, id_ex_clear=1; flush_events=1; the next fetch is accepted normally.
- Mispredict while imem_ready=0, ready arriving 3 cycles later → the drop flag discards that fetch (if_id_clear=1 on it); the following fetch loads with if_id_enable=1.
- dmem wait of 4 cycles coinciding with a load-use → 4 freeze cycles with all enables 0, then 1 load-use bubble; stall_cycles=5.
- Timeout with DMEM_TIMEOUT=3, dmem_ready held 0 → dmem_timeout rises on the 4th DWAIT cycle and stays 1 after dmem_ready; cleared only by reset=0.
- Async reset mid-DWAIT → state RUN, counters 0, dmem_timeout 0 without a clock edge; pc_enable follows the current inputs.
